dm_store_buffer: RTL and testbench

//  Store-side counterpart of the DM load-extract path. It takes sw/sh/sb requests from the MEM stage.
//  It lane-replicates the store data and generates byte enables from addr[1:0].

---
 rtl/dm_store_buffer_pkg.sv | 22 ++
 rtl/dm_store_align.sv | 53 +++++
 rtl/dm_store_buffer.sv | 158 +++++++++++++++
 tb/tb_dm_store_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_store_buffer_pkg
// Description : Shared constants for the data-memory store buffer.
//               - Store access-type codes driven on req_type by the MEM
//                 stage (word / half / byte). Any other code is treated as
//                 an unsupported store.
//               - Default store-buffer depth.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_store_buffer_pkg;

    // Store access-type encodings seen on req_type.
    localparam logic [5:0] WORD_DM  = 6'd1;
    localparam logic [5:0] HALF_DM  = 6'd2;
    localparam logic [5:0] BYTE_DM  = 6'd3;

    // Default number of store-buffer entries (power of two, >= 2).
    localparam int         SB_DEPTH = 2;

endpackage : dm_store_buffer_pkg
`default_nettype wire

// File: rtl/dm_store_align.sv
`default_nettype none
// ============================================================================
// Module      : dm_store_align
// Description : Purely combinational store lane generator.
//               Replicates right-justified store data across the byte lanes,
//               builds byte enables from the low address bits and flags
//               misaligned or unsupported store types.
// Ports       : i_req_type  [5:0]  store access type (WORD/HALF/BYTE_DM)
//               i_addr_lo   [1:0]  byte offset within the word
//               i_data      [31:0] store data, right-justified
//               o_wdata     [31:0] lane-replicated write data
//               o_be        [3:0]  byte enables, bit i = byte lane i
//               o_misalign         store is misaligned or type unsupported
// Revision    : 1.0 - initial release
// ============================================================================
module dm_store_align
    import dm_store_buffer_pkg::*;
(
    input  logic [5:0]  i_req_type,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_data,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic        o_misalign
);

    always_comb begin
        o_wdata    = i_data;
        o_be       = 4'b0000;
        o_misalign = 1'b0;
        case (i_req_type)
            BYTE_DM: begin
                o_wdata = {4{i_data[7:0]}};
                o_be    = 4'b0001 << i_addr_lo;
            end
            HALF_DM: begin
                o_wdata    = {2{i_data[15:0]}};
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_addr_lo[0];
            end
            WORD_DM: begin
                o_be       = 4'b1111;
                o_misalign = (i_addr_lo != 2'b00);
            end
            default: begin
                // Unknown access type: never written, reported as an error.
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule : dm_store_align
`default_nettype wire

// File: rtl/dm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dm_store_buffer
// Description : In-order store buffer between the MEM stage and the
//               data-memory write port. Stores are lane-replicated and given
//               byte enables on accept, held in a small FIFO and drained over
//               a valid/ready handshake. Misaligned stores are dropped and
//               reported; loads hitting a pending store word are flagged.
// Ports       : clk, reset_n              clock, async active-low reset
//               req_valid/req_ready       store request handshake
//               req_type/addr/data        store request fields
//               mem_valid/mem_ready       memory write handshake (head entry)
//               mem_addr/wdata/be         head entry word address/data/enables
//               ld_addr / ld_hit          load-vs-pending-store word match
//               err_misalign / err_addr   error pulse and last errored address
//               empty                     no pending entries
// Revision    : 1.0 - initial release
// ============================================================================
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic              err_misalign,
    output logic [ADDR_W-1:0] err_addr,
    output logic              empty
);

    localparam int                  c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]    c_depth   = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w:0]    c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0]  c_ptr_one = c_ptr_w'(1);

    // Entry storage: word address only, the byte offset lives in the enables.
    logic [ADDR_W-3:0]   r_ent_addr  [DEPTH];
    logic [31:0]         r_ent_wdata [DEPTH];
    logic [3:0]          r_ent_be    [DEPTH];
    logic [DEPTH-1:0]    r_ent_vld;

    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w:0]    r_count;
    logic [c_ptr_w:0]    w_count_nxt;
    logic                r_ready;
    logic                r_err;
    logic [ADDR_W-1:0]   r_err_addr;

    logic [31:0]         w_al_wdata;
    logic [3:0]          w_al_be;
    logic                w_al_misalign;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_ld_hit;
    logic                w_ld_lo_unused;

    dm_store_align u_align (
        .i_req_type (req_type),
        .i_addr_lo  (req_addr[1:0]),
        .i_data     (req_data),
        .o_wdata    (w_al_wdata),
        .o_be       (w_al_be),
        .o_misalign (w_al_misalign)
    );

    // req_ready is a flop, so there is no path from mem_ready to req_ready.
    assign w_accept = req_valid && r_ready;
    assign w_push   = w_accept && !w_al_misalign;
    assign w_pop    = mem_valid && mem_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_ready    <= 1'b1;
            r_ent_vld  <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt < c_depth);
            // Clear before set: push and pop never share a slot because a
            // full buffer cannot push and an empty one cannot pop.
            if (w_pop) begin
                r_ent_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr            <= r_rd_ptr + c_ptr_one;
            end
            if (w_push) begin
                r_ent_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr            <= r_wr_ptr + c_ptr_one;
            end
            r_err <= w_accept && w_al_misalign;
            if (w_accept && w_al_misalign) begin
                r_err_addr <= req_addr;
            end
        end
    end

    // Payload is qualified by r_ent_vld / r_count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ent_addr[r_wr_ptr]  <= req_addr[ADDR_W-1:2];
            r_ent_wdata[r_wr_ptr] <= w_al_wdata;
            r_ent_be[r_wr_ptr]    <= w_al_be;
        end
    end

    // Only entries already written count; a store accepted this cycle is not
    // visible until the following cycle.
    always_comb begin
        w_ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_ent_vld[i] && (r_ent_addr[i] == ld_addr[ADDR_W-1:2])) begin
                w_ld_hit = 1'b1;
            end
        end
    end

    // Load byte offset is irrelevant to a word-granular hazard check.
    assign w_ld_lo_unused = ^ld_addr[1:0];

    assign req_ready    = r_ready;
    assign mem_valid    = (r_count != '0);
    assign mem_addr     = {r_ent_addr[r_rd_ptr], 2'b00};
    assign mem_wdata    = r_ent_wdata[r_rd_ptr];
    assign mem_be       = r_ent_be[r_rd_ptr];
    assign ld_hit       = w_ld_hit;
    assign err_misalign = r_err;
    assign err_addr     = r_err_addr;
    assign empty        = (r_count == '0);

endmodule : dm_store_buffer
`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_store_buffer
// Description : Self-checking bench for dm_store_buffer: a vector table for
//               single stores, hand sequences for back-pressure, load hits,
//               back-to-back errors and mid-drain reset, and a randomized
//               run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_store_buffer;
    import dm_store_buffer_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [5:0]        req_type = WORD_DM;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_data = '0;
    logic              mem_valid;
    logic              mem_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic              ld_hit;
    logic              err_misalign;
    logic [ADDR_W-1:0] err_addr;
    logic              empty;

    int n_total = 0;
    int n_pass  = 0;

    dm_store_buffer #(.DEPTH(SB_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_type     (req_type),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .ld_addr      (ld_addr),
        .ld_hit       (ld_hit),
        .err_misalign (err_misalign),
        .err_addr     (err_addr),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [5:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference lane rules written with plain arithmetic.
    function automatic void model_lanes(input logic [5:0] t, input logic [31:0] a,
                                        input logic [31:0] d, output logic [31:0] wd,
                                        output logic [3:0] be, output logic err);
        int off;
        off = int'(a % 4);
        wd  = d;
        be  = 4'h0;
        err = 1'b0;
        if (t == BYTE_DM) begin
            wd = (d & 32'hFF) * 32'h01010101;
            be = 4'(1 << off);
        end else if (t == HALF_DM) begin
            wd  = (d & 32'hFFFF) * 32'h00010001;
            be  = (off >= 2) ? 4'hC : 4'h3;
            err = (off % 2) != 0;
        end else if (t == WORD_DM) begin
            be  = 4'hF;
            err = off != 0;
        end else begin
            err = 1'b1;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    vec_t vecs[10];

    initial begin
        ent_t        q[$];
        logic        m_ready;
        logic        m_err;
        logic [31:0] m_err_addr;

        vecs[0] = '{BYTE_DM, 32'h1003, 32'h000000AB, 32'hABABABAB, 4'b1000, 1'b0};
        vecs[1] = '{HALF_DM, 32'h2002, 32'h00001234, 32'h12341234, 4'b1100, 1'b0};
        vecs[2] = '{HALF_DM, 32'h2000, 32'hDEAD5678, 32'h56785678, 4'b0011, 1'b0};
        vecs[3] = '{WORD_DM, 32'h3000, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, 1'b0};
        vecs[4] = '{BYTE_DM, 32'h1001, 32'h123456C3, 32'hC3C3C3C3, 4'b0010, 1'b0};
        vecs[5] = '{WORD_DM, 32'h3001, 32'h11111111, 32'h0,        4'b0000, 1'b1};
        vecs[6] = '{HALF_DM, 32'h3003, 32'h22222222, 32'h0,        4'b0000, 1'b1};
        vecs[7] = '{WORD_DM, 32'h3002, 32'h33333333, 32'h0,        4'b0000, 1'b1};
        vecs[8] = '{6'd0,    32'h3100, 32'h44444444, 32'h0,        4'b0000, 1'b1};
        vecs[9] = '{BYTE_DM, 32'h1000, 32'h0000007F, 32'h7F7F7F7F, 4'b0001, 1'b0};

        // ---------------- reset state ----------------
        #12;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_err", err_misalign, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_ld_hit", ld_hit, 0);
        do_reset();

        // ---------------- vector table, mem_ready=1 ----------------
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_type  = vecs[i].typ;
            req_addr  = vecs[i].addr;
            req_data  = vecs[i].data;
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            chk($sformatf("v%0d_err", i), err_misalign, vecs[i].exp_err);
            chk($sformatf("v%0d_mem_valid", i), mem_valid, !vecs[i].exp_err);
            if (vecs[i].exp_err) begin
                chk($sformatf("v%0d_err_addr", i), err_addr, vecs[i].addr);
            end else begin
                chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].addr & 32'hFFFFFFFC);
                chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
                chk($sformatf("v%0d_be", i), mem_be, vecs[i].exp_be);
            end
            tick();
            chk($sformatf("v%0d_empty_after", i), empty, 1);
            chk($sformatf("v%0d_err_cleared", i), err_misalign, 0);
        end

        // ---------------- back-pressure and FIFO order ----------------
        mem_ready = 1'b0;
        req_type  = WORD_DM;
        req_valid = 1'b1;
        req_addr  = 32'h10; req_data = 32'h11111111;
        tick();
        req_addr  = 32'h14; req_data = 32'h22222222;
        tick();
        chk("bp_ready_low", req_ready, 0);
        req_addr  = 32'h18; req_data = 32'h33333333;
        tick();
        chk("bp_ready_still_low", req_ready, 0);
        chk("bp_head_held", mem_addr, 32'h10);
        chk("bp_head_data", mem_wdata, 32'h11111111);
        mem_ready = 1'b1;
        #1;
        chk("bp_write0_addr", mem_addr, 32'h10);
        tick();
        chk("bp_write1_addr", mem_addr, 32'h14);
        chk("bp_ready_after_pop", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("bp_write2_addr", mem_addr, 32'h18);
        chk("bp_write2_data", mem_wdata, 32'h33333333);
        chk("bp_write2_valid", mem_valid, 1);
        tick();
        chk("bp_drained", empty, 1);

        // ---------------- back-to-back errors ----------------
        req_valid = 1'b1;
        req_addr  = 32'h3001;
        tick();
        chk("b2b_err0", err_misalign, 1);
        chk("b2b_addr0", err_addr, 32'h3001);
        req_addr  = 32'h3006;
        tick();
        req_valid = 1'b0;
        chk("b2b_err1", err_misalign, 1);
        chk("b2b_addr1", err_addr, 32'h3006);
        tick();
        chk("b2b_err_off", err_misalign, 0);

        // ---------------- load hit ----------------
        mem_ready = 1'b0;
        ld_addr   = 32'h5000;
        req_addr  = 32'h5000;
        req_valid = 1'b1;
        #1;
        chk("hit_same_cycle_excluded", ld_hit, 0);
        req_addr  = 32'h4000;
        tick();
        req_valid = 1'b0;
        ld_addr   = 32'h4002;
        #1;
        chk("hit_pending", ld_hit, 1);
        ld_addr   = 32'h4004;
        #1;
        chk("hit_other_word", ld_hit, 0);
        mem_ready = 1'b1;
        tick();
        ld_addr   = 32'h4002;
        #1;
        chk("hit_after_drain", ld_hit, 0);

        // ---------------- reset while full ----------------
        mem_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h6000;
        tick();
        req_addr  = 32'h6004;
        tick();
        req_valid = 1'b0;
        ld_addr   = 32'h6000;
        #1;
        chk("full_ready", req_ready, 0);
        chk("full_hit", ld_hit, 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_mem_valid", mem_valid, 0);
        chk("midrst_ld_hit", ld_hit, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("postrst_empty", empty, 1);
        chk("postrst_ready", req_ready, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("postrst_no_write", mem_valid, 0);
        end

        // ---------------- randomized vs reference model ----------------
        do_reset();
        q.delete();
        m_ready    = 1'b1;
        m_err      = 1'b0;
        m_err_addr = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [31:0] wd;
            logic [3:0]  be;
            logic        err;
            logic        exp_hit;
            logic        acc;
            logic        popd;
            int          sel;

            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       req_type = WORD_DM;
                1:       req_type = HALF_DM;
                2, 3:    req_type = BYTE_DM;
                default: req_type = 6'($urandom_range(4, 63));
            endcase
            req_valid = ($urandom_range(0, 3) != 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            req_addr  = 32'h100 + $urandom_range(0, 31);
            req_data  = $urandom;
            ld_addr   = 32'h100 + $urandom_range(0, 31);
            #1;

            exp_hit = 1'b0;
            foreach (q[k]) if (q[k].waddr == (ld_addr & 32'hFFFFFFFC)) exp_hit = 1'b1;
            chk("rnd_mem_valid", mem_valid, q.size() != 0);
            chk("rnd_empty", empty, q.size() == 0);
            chk("rnd_req_ready", req_ready, m_ready);
            chk("rnd_err", err_misalign, m_err);
            chk("rnd_err_addr", err_addr, m_err_addr);
            chk("rnd_ld_hit", ld_hit, exp_hit);
            if (q.size() != 0) begin
                chk("rnd_mem_addr", mem_addr, q[0].waddr);
                chk("rnd_mem_wdata", mem_wdata, q[0].wdata);
                chk("rnd_mem_be", mem_be, q[0].be);
            end

            model_lanes(req_type, req_addr, req_data, wd, be, err);
            acc  = req_valid && m_ready;
            popd = (q.size() != 0) && mem_ready;
            if (popd) void'(q.pop_front());
            if (acc && !err) q.push_back('{req_addr & 32'hFFFFFFFC, wd, be});
            m_err = acc && err;
            if (m_err) m_err_addr = req_addr;
            m_ready = (q.size() < SB_DEPTH);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dm_store_buffer
`default_nettype wire
